// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        STOP,
        ACK,
        WAIT_IDLE,
        ERR
    } ps2_tx_state_e;

    localparam int PS2_DATA_BITS     = 8;
    localparam int PS2_TX_SHIFT_BITS = 9;
    localparam int PS2_MAX_RETRY     = 2;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

    function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a one-cycle
// falling-edge pulse on the clock; usable by both the transmit and receive paths.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [1:0] clk_sr_q, clk_sr_d;
    logic [1:0] data_sr_q, data_sr_d;
    logic       clk_prev_q, clk_prev_d;

    always_comb begin
        clk_sr_d   = {clk_sr_q[0], ps2_clk};
        data_sr_d  = {data_sr_q[0], ps2_data};
        clk_prev_d = clk_sr_q[1];
    end

    // Preset high so a released bus never produces a spurious fall after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sr_q   <= 2'b11;
            data_sr_q  <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sr_q   <= clk_sr_d;
            data_sr_q  <= data_sr_d;
            clk_prev_q <= clk_prev_d;
        end
    end

    assign clk_sync  = clk_sr_q[1];
    assign data_sync = data_sr_q[1];
    assign clk_fall  = clk_prev_q & ~clk_sr_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, frame, ack).
// Optional PS2_TX_RETRY_EN re-runs a failed frame up to PS2_MAX_RETRY times.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e                 state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [PS2_TX_SHIFT_BITS-1:0]  shift_q, shift_d;
    logic [3:0]                    bit_idx_q, bit_idx_d;
    logic                          clk_oe_q, clk_oe_d;
    logic                          data_oe_q, data_oe_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]                    retry_q, retry_d;
    logic [7:0]                    byte_q, byte_d;
`endif

    logic clk_sync, data_sync, clk_fall;

    ps2_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fall  (clk_fall)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
        byte_d    = byte_q;
`endif
        case (state_q)
            IDLE: if (tx_valid) begin
                shift_d   = {ps2_odd_parity(tx_data), tx_data};
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                cnt_d     = '0;
                state_d   = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                retry_d   = '0;
                byte_d    = tx_data;
`endif
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = RTS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RTS: begin
                clk_oe_d  = 1'b0;
                cnt_d     = '0;
                bit_idx_d = '0;
                state_d   = SEND;
            end
            // Data only moves on a detected fall, so it is settled by the device's rising-edge sample.
            SEND: if (clk_fall) begin
                data_oe_d = ~shift_q[0];
                shift_d   = {1'b0, shift_q[PS2_TX_SHIFT_BITS-1:1]};
                bit_idx_d = bit_idx_q + 4'd1;
                if (bit_idx_q == 4'd8) state_d = STOP;
            end
            STOP: if (clk_fall) begin
                data_oe_d = 1'b0;
                state_d   = ACK;
            end
            ACK: if (clk_fall) begin
                state_d = data_sync ? ERR : WAIT_IDLE;
            end
            WAIT_IDLE: if (clk_sync && data_sync) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
`ifdef PS2_TX_RETRY_EN
                if (retry_q < 2'(PS2_MAX_RETRY)) begin
                    retry_d  = retry_q + 2'd1;
                    shift_d  = {ps2_odd_parity(byte_q), byte_q};
                    clk_oe_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = INHIBIT;
                end else begin
                    err_d = 1'b1;
                end
`else
                err_d = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Watchdog over the device-clocked phases; a completing WAIT_IDLE wins.
        if (state_q inside {SEND, STOP, ACK, WAIT_IDLE}) begin
            if (clk_fall) begin
                cnt_d = '0;
            end else if (cnt_q == TO_LAST && !done_d) begin
                state_d   = ERR;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= '0;
            byte_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= retry_d;
            byte_q    <= byte_d;
`endif
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign tx_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model with a clocking device model,
// table-driven command vectors plus hand sequences for back-to-back, timeout and reset.
module tb_ps2_host_tx;

    localparam int INH      = 10;
    localparam int TO       = 4000;
    localparam int DEV_HALF = 100;   // device clock scaled down to keep the run short
    localparam int BOUND    = 15000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe;
    logic       tx_ready, tx_done, tx_err, busy;

    assign ps2_clk  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .CNT_W(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .busy        (busy)
    );

    typedef struct {
        logic [7:0] cmd;
        bit         ack;
        bit         par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    typedef struct {
        logic [10:0] frame;
        int          exp_done;
        int          exp_err;
    } exp_t;

    vec_t vecs [4];
    exp_t sb [$];

    int vectors = 0, miscompares = 0;

    int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, rise_cnt = 0;
    int last_done_cyc = 0, last_err_cyc = 0, last_rise_cyc = 0, last_rel_cyc = 0;
    logic [1:0] err_oe_snap = 2'b11;
    logic       err_rdy_snap = 1'b0;
    logic       prev_clk_oe = 1'b0;

    always @(negedge clk) begin
        cyc         <= cyc + 1;
        prev_clk_oe <= ps2_clk_oe;
        if (tx_done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (tx_err) begin
            err_cnt      <= err_cnt + 1;
            last_err_cyc <= cyc;
            err_oe_snap  <= {ps2_clk_oe, ps2_data_oe};
            err_rdy_snap <= tx_ready;
        end
        if (tx_done && tx_err) both_cnt <= both_cnt + 1;
        if (ps2_clk_oe && !prev_clk_oe) begin
            rise_cnt      <= rise_cnt + 1;
            last_rise_cyc <= cyc;
        end
        if (!ps2_clk_oe && prev_clk_oe) last_rel_cyc <= cyc;
    end

    function automatic logic [10:0] exp_frame(input logic [7:0] c, input logic p);
        return {1'b1, p, c, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic send(input logic [7:0] cmd, input bit keep);
        int n = 0;
        @(negedge clk);
        tx_data  = cmd;
        tx_valid = 1'b1;
        while (!tx_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 32'(n < BOUND), 1);
        @(negedge clk);
        if (!keep) tx_valid = 1'b0;
    endtask

    // Device sees request-to-send: host clock released while data is held low.
    task automatic wait_rts(output bit ok);
        int n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        ok = (n < BOUND);
        chk("rts_seen", 32'(ok), 1);
    endtask

    task automatic dev_pulses(input int count);
        for (int i = 0; i < count; i++) begin
            dev_clk = 1'b0;
            repeat (DEV_HALF) @(negedge clk);
            dev_clk = 1'b1;
            repeat (DEV_HALF) @(negedge clk);
        end
    endtask

    task automatic dev_frame(input bit ack, output logic [10:0] obs);
        bit ok;
        obs = '0;
        wait_rts(ok);
        if (ok) begin
            repeat (DEV_HALF) @(negedge clk);
            obs[0] = ps2_data;
            for (int i = 1; i <= 11; i++) begin
                if (i == 11) dev_data = ack ? 1'b0 : 1'b1;
                dev_clk = 1'b0;
                repeat (DEV_HALF) @(negedge clk);
                dev_clk = 1'b1;
                if (i <= 10) obs[i] = ps2_data;
                repeat (DEV_HALF) @(negedge clk);
            end
            dev_data = 1'b1;
        end
    endtask

    task automatic wait_outcome(input int d0, input int e0);
        int n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk("outcome_in_time", 32'(n < BOUND), 1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [10:0] obs;
        exp_t        e;
        int          d0, e0, r0, n;

        vecs[0] = '{cmd: 8'hED, ack: 1'b1, par: 1'b1, exp_done: 1, exp_err: 0};
        vecs[1] = '{cmd: 8'h00, ack: 1'b1, par: 1'b1, exp_done: 1, exp_err: 0};
        vecs[2] = '{cmd: 8'hF4, ack: 1'b0, par: 1'b0, exp_done: 0, exp_err: 1};
        vecs[3] = '{cmd: 8'hA5, ack: 1'b1, par: 1'b1, exp_done: 1, exp_err: 0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
        chk("rst_data_oe", 32'(ps2_data_oe), 0);
        chk("rst_done_err", {30'd0, tx_done, tx_err}, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(tx_ready), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send(vecs[i].cmd, 1'b0);
            sb.push_back('{frame: exp_frame(vecs[i].cmd, vecs[i].par),
                           exp_done: vecs[i].exp_done, exp_err: vecs[i].exp_err});
            dev_frame(vecs[i].ack, obs);
            e = sb.pop_front();
            chk($sformatf("frame_%02h", vecs[i].cmd), 32'(obs), 32'(e.frame));
            wait_outcome(d0, e0);
            chk($sformatf("done_%02h", vecs[i].cmd), done_cnt - d0, e.exp_done);
            chk($sformatf("err_%02h", vecs[i].cmd), err_cnt - e0, e.exp_err);
            if (!vecs[i].ack) begin
                chk("nack_err_oe", 32'(err_oe_snap), 0);
                chk("nack_err_ready", 32'(err_rdy_snap), 1);
            end
        end

        // Back-to-back: tx_valid held, second byte accepted right after the first tx_done.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h01, 1'b1);
        tx_data = 8'hFF;
        dev_frame(1'b1, obs);
        chk("b2b_frame_01", 32'(obs), 32'(exp_frame(8'h01, 1'b0)));
        n = 0;
        while (done_cnt == d0 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("b2b_accept_cycle", last_rise_cyc, last_done_cyc + 1);
        tx_valid = 1'b0;
        dev_frame(1'b1, obs);
        chk("b2b_frame_ff", 32'(obs), 32'(exp_frame(8'hFF, 1'b1)));
        wait_outcome(d0 + 1, e0);
        chk("b2b_done_count", done_cnt - d0, 2);
        chk("b2b_err_count", err_cnt - e0, 0);

        // Silent device: tx_err lands one registered cycle after the watchdog expires.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hF4, 1'b0);
        wait_outcome(d0, e0);
        chk("to_latency", last_err_cyc - last_rel_cyc, TO + 1);
        chk("to_err_count", err_cnt - e0, 1);
        chk("to_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);

        // Reset in the middle of SEND after four device falls.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hED, 1'b0);
        begin
            bit ok;
            wait_rts(ok);
            if (ok) begin
                repeat (DEV_HALF) @(negedge clk);
                dev_pulses(4);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_mid_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_mid_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        d0 = done_cnt;
        send(8'hED, 1'b0);
        dev_frame(1'b1, obs);
        chk("post_rst_frame", 32'(obs), 32'(exp_frame(8'hED, 1'b1)));
        wait_outcome(d0, e0);
        chk("post_rst_done", done_cnt - d0, 1);

`ifdef PS2_TX_RETRY_EN
        d0 = done_cnt;
        e0 = err_cnt;
        r0 = rise_cnt;
        send(8'hFF, 1'b0);
        for (int k = 0; k < 3; k++) begin
            dev_frame(k == 2, obs);
            chk("retry_frame", 32'(obs), 32'(exp_frame(8'hFF, 1'b1)));
        end
        wait_outcome(d0, e0);
        chk("retry_inhibits", rise_cnt - r0, 3);
        chk("retry_done", done_cnt - d0, 1);
        chk("retry_err", err_cnt - e0, 0);

        d0 = done_cnt;
        e0 = err_cnt;
        r0 = rise_cnt;
        send(8'hF4, 1'b0);
        for (int k = 0; k < 3; k++) dev_frame(1'b0, obs);
        wait_outcome(d0, e0);
        chk("retry3_inhibits", rise_cnt - r0, 3);
        chk("retry3_done", done_cnt - d0, 0);
        chk("retry3_err", err_cnt - e0, 1);
`else
        r0 = 0;
`endif

        chk("done_err_coincident", both_cnt, 0 + r0 - r0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
